datamover_ctrl_fsm: RTL and testbench
=====================================

# datamover_ctrl_fsm

Sequencing controller for the datamover streaming datapath: runs a tiled memory-to-memory copy by repeatedly launching the input source and output sink streamers. Each launch covers one tile, and the controller waits for completion and for the TCDM FIFO to drain before advancing both addresses. It sits between the register-file/control slave (start, configuration, done event) and the streamer pair (`ctrl_streamer_t` / `flags_streamer_t` from `datamover_package`).

## Interface
Parameters:
- `BYTES_PER_WORD`, 4, address increment per streamed word (`d0_stride`)
- `LEN_W`, 16, width of tile length (words)
- `NT_W`, 16, width of tile count

Ports:
- `clk_i`  in  1  clock
- `clear_i`  in  1  reset: one clock domain, synchronous, active-high
- `start_i`  in  1  start pulse from the control slave; sampled only in IDLE
- `src_base_i`  in  32  byte address of the first source tile
- `dst_base_i`  in  32  byte address of the first sink tile
- `src_tstride_i`  in  32  source address increment between tiles (bytes)
- `dst_tstride_i`  in  32  sink address increment between tiles (bytes)
- `tile_len_i`  in  LEN_W  words per tile
- `n_tiles_i`  in  NT_W  number of tiles
- `ctrl_streamer_o`  out  `ctrl_streamer_t`  source/sink start and address-generator configuration
- `flags_streamer_i`  in  `flags_streamer_t`  `ready_start`/`done` of each streamer, plus `tcdm_fifo_empty`
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle end-of-job pulse
- `tile_idx_o`  out  NT_W  index of the current tile

## Operation
- **IDLE:**
  - When `start_i`=1, latch all configuration inputs.
  - Load the current addresses with the bases and set `tile_idx`=0.
  - Go to DONE if `n_tiles_i`=0 or `tile_len_i`=0; otherwise go to START.
  - `start_i` in any other state is ignored.
- **START:**
  - Drive `req_start`=1 on both streamers only in a cycle where both `ready_start`=1; then go to WAIT.
  - Otherwise hold `req_start`=0 and stay in START.
  - The two streamers are never started in different cycles.
- **WAIT:**
  - Latch `src_done` and `snk_done` as sticky bits; the streamer `done` flags are single-cycle pulses.
  - A pulse arriving in the same cycle as entry to WAIT is captured.
  - Go to DRAIN once both bits are set, counting a pulse arriving in the current cycle.
- **DRAIN:**
  - Stay until `tcdm_fifo_empty`=1, then go to NEXT.
- **NEXT:**
  - Clear the sticky bits.
  - If `tile_idx`=`n_tiles`-1, go to DONE.
  - Otherwise `tile_idx`+=1, `src_addr`+=`src_tstride`, `dst_addr`+=`dst_tstride`, and go to START.
  - Addresses are 32-bit and wrap modulo 2^32; strides are unsigned.
- **DONE:**
  - `done_o`=1 for exactly this cycle, then go to IDLE.
- **ctrl_streamer_o**, driven from registers:
  - Address generator: `base_addr` = current address, `tot_len` = `d0_len` = `tile_len`, `d0_stride` = `BYTES_PER_WORD`.
  - All other address-generator fields are zero.
  - `req_start` is combinational as defined in START.
- **Reset (`clear_i`=1) in any state:**
  - Next state is IDLE; counters, addresses and sticky bits go to 0.
  - Reset dominates `start_i` in the same cycle.
  - Any in-flight streamer activity is the streamers' own concern; they share `clear_i`.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `tile_idx_o`=0, both `req_start`=0, all `ctrl_streamer_o` address fields 0.
- `start_i` at cycle N → START at N+1 → `req_start` at N+1 at the earliest (both streamers ready).
- Last `done` pulse at cycle M (FIFO already empty) → DRAIN at M+1 → NEXT at M+2 → `req_start` for the next tile at M+3 at the earliest.
- Zero-work job: `start_i` at N → `done_o` at N+1, `busy_o` high only at N+1.
- `tile_idx_o` and the addresses update on the clock edge leaving NEXT; they are stable throughout START, WAIT and DRAIN.

## Structure
- Add to `datamover_package`:
  - `datamover_fsm_state_e` (IDLE, START, WAIT, DRAIN, NEXT, DONE)
  - `datamover_job_cfg_t` (the latched configuration fields)
- One sub-module, `datamover_tile_counter`, holds the tile index and both address accumulators, with load and step inputs and a `last` output.

## Test plan
- `n_tiles`=3, `tile_len`=16, `src`=0x1000, `dst`=0x2000, strides 0x40/0x80 → three `req_start` pulses with `base_addr` 0x1000/0x1040/0x1080 and 0x2000/0x2080/0x2100, then a single `done_o`.
- `ready_start` of the sink low for 5 cycles, source high → no `req_start` until both are high, then both streamers start in the same cycle.
- Source and sink `done` in the same cycle, and separately sink 7 cycles after source → DRAIN is entered the cycle after the later pulse.
- `tcdm_fifo_empty` held low for 10 cycles after both dones → NEXT follows the first empty cycle.
- `n_tiles`=0, and separately `tile_len`=0 → `done_o` one cycle after `start_i`, with no `req_start`.
- `clear_i` asserted in WAIT of tile 1, with `start_i` high in that same cycle → IDLE with all outputs at reset values; a later `start_i` runs the full job from tile 0.

Source files
------------

// File: rtl/datamover_package.sv
// Shared types for the datamover: streamer control/flag bundles, controller FSM states and job config.
package datamover_package;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
    logic [1:0]  dim_enable_1h;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef struct packed {
    ctrl_sourcesink_t data_in_source_ctrl;
    ctrl_sourcesink_t data_out_sink_ctrl;
  } ctrl_streamer_t;

  typedef struct packed {
    flags_sourcesink_t data_in_source_flags;
    flags_sourcesink_t data_out_sink_flags;
    logic              tcdm_fifo_empty;
  } flags_streamer_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } datamover_fsm_state_e;

  typedef struct packed {
    logic [31:0] src_tstride;
    logic [31:0] dst_tstride;
    logic [31:0] tile_len;
    logic [31:0] n_tiles;
    logic [31:0] d0_stride;
  } datamover_job_cfg_t;

  // One-dimensional tile: only base, lengths and the word stride are non-zero.
  function automatic addressgen_ctrl_t tile_addressgen(input logic [31:0] base,
                                                       input logic [31:0] len,
                                                       input logic [31:0] stride);
    addressgen_ctrl_t a;
    a           = '0;
    a.base_addr = base;
    a.tot_len   = len;
    a.d0_len    = len;
    a.d0_stride = stride;
    return a;
  endfunction

endpackage

// File: rtl/datamover_ctrl_fsm_if.sv
// Controller <-> streamer-pair bundle: start/config towards the streamers, ready/done/fifo flags back.
interface datamover_ctrl_fsm_if;
  import datamover_package::*;

  ctrl_streamer_t  ctrl_streamer;
  flags_streamer_t flags_streamer;

  modport master (output ctrl_streamer, input flags_streamer);
  modport slave  (input ctrl_streamer, output flags_streamer);
endinterface

// File: rtl/datamover_tile_counter.sv
// Tile index and source/sink address accumulators; load on job start, step between tiles.
module datamover_tile_counter #(
  parameter int unsigned NT_W = 16
) (
  input  logic            clk_i,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [31:0]     src_base_i,
  input  logic [31:0]     dst_base_i,
  input  logic [31:0]     src_tstride_i,
  input  logic [31:0]     dst_tstride_i,
  input  logic [31:0]     n_tiles_i,
  output logic [NT_W-1:0] tile_idx_o,
  output logic [31:0]     src_addr_o,
  output logic [31:0]     dst_addr_o,
  output logic            last_o
);

  logic [NT_W-1:0] tile_idx_q, tile_idx_d;
  logic [31:0]     src_addr_q, src_addr_d;
  logic [31:0]     dst_addr_q, dst_addr_d;

  always_comb begin
    tile_idx_d = tile_idx_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    if (load_i) begin
      tile_idx_d = '0;
      src_addr_d = src_base_i;
      dst_addr_d = dst_base_i;
    end else if (step_i) begin
      tile_idx_d = tile_idx_q + NT_W'(1);
      src_addr_d = src_addr_q + src_tstride_i;
      dst_addr_d = dst_addr_q + dst_tstride_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      tile_idx_q <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
    end else begin
      tile_idx_q <= tile_idx_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
    end
  end

  assign tile_idx_o = tile_idx_q;
  assign src_addr_o = src_addr_q;
  assign dst_addr_o = dst_addr_q;
  assign last_o     = (32'(tile_idx_q) == (n_tiles_i - 32'd1));

endmodule

// File: rtl/datamover_ctrl_fsm.sv
// Tiled copy sequencer: launches source+sink per tile, waits for both dones and an empty TCDM FIFO,
// then steps addresses. req_start is the only combinational output.
module datamover_ctrl_fsm
  import datamover_package::*;
#(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned NT_W           = 16
) (
  input  logic                      clk_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [31:0]               src_base_i,
  input  logic [31:0]               dst_base_i,
  input  logic [31:0]               src_tstride_i,
  input  logic [31:0]               dst_tstride_i,
  input  logic [LEN_W-1:0]          tile_len_i,
  input  logic [NT_W-1:0]           n_tiles_i,
  datamover_ctrl_fsm_if.master      strm,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [NT_W-1:0]           tile_idx_o
);

  datamover_fsm_state_e state_q;
  datamover_job_cfg_t   cfg_q, cfg_d;
  logic                 busy_q, done_q;
  logic                 src_done_q, snk_done_q;

  flags_streamer_t flags;
  ctrl_streamer_t  ctrl;
  logic            both_ready, req_start, src_done_now, snk_done_now, job_empty;
  logic            cnt_load, cnt_step, cnt_last;
  logic [31:0]     src_addr, dst_addr;

  assign flags        = strm.flags_streamer;
  assign both_ready   = flags.data_in_source_flags.ready_start & flags.data_out_sink_flags.ready_start;
  assign req_start    = (state_q == ST_START) & both_ready;
  assign src_done_now = src_done_q | flags.data_in_source_flags.done;
  assign snk_done_now = snk_done_q | flags.data_out_sink_flags.done;
  assign job_empty    = (n_tiles_i == '0) || (tile_len_i == '0);
  assign cnt_load     = (state_q == ST_IDLE) & start_i;
  assign cnt_step     = (state_q == ST_NEXT) & ~cnt_last;

  always_comb begin
    cfg_d             = '0;
    cfg_d.src_tstride = src_tstride_i;
    cfg_d.dst_tstride = dst_tstride_i;
    cfg_d.tile_len    = 32'(tile_len_i);
    cfg_d.n_tiles     = 32'(n_tiles_i);
    cfg_d.d0_stride   = 32'(BYTES_PER_WORD);
  end

  datamover_tile_counter #(.NT_W(NT_W)) i_tile_counter (
    .clk_i         (clk_i),
    .clear_i       (clear_i),
    .load_i        (cnt_load),
    .step_i        (cnt_step),
    .src_base_i    (src_base_i),
    .dst_base_i    (dst_base_i),
    .src_tstride_i (cfg_q.src_tstride),
    .dst_tstride_i (cfg_q.dst_tstride),
    .n_tiles_i     (cfg_q.n_tiles),
    .tile_idx_o    (tile_idx_o),
    .src_addr_o    (src_addr),
    .dst_addr_o    (dst_addr),
    .last_o        (cnt_last)
  );

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_done_q <= 1'b0;
      snk_done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cfg_q  <= cfg_d;
            busy_q <= 1'b1;
            if (job_empty) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_START;
            end
          end
        end
        ST_START: if (req_start) state_q <= ST_WAIT;
        ST_WAIT: begin
          // done flags are single-cycle pulses, so hold them until both have arrived
          src_done_q <= src_done_now;
          snk_done_q <= snk_done_now;
          if (src_done_now && snk_done_now) state_q <= ST_DRAIN;
        end
        ST_DRAIN: if (flags.tcdm_fifo_empty) state_q <= ST_NEXT;
        ST_NEXT: begin
          src_done_q <= 1'b0;
          snk_done_q <= 1'b0;
          if (cnt_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_START;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl                                     = '0;
    ctrl.data_in_source_ctrl.req_start       = req_start;
    ctrl.data_out_sink_ctrl.req_start        = req_start;
    ctrl.data_in_source_ctrl.addressgen_ctrl = tile_addressgen(src_addr, cfg_q.tile_len, cfg_q.d0_stride);
    ctrl.data_out_sink_ctrl.addressgen_ctrl  = tile_addressgen(dst_addr, cfg_q.tile_len, cfg_q.d0_stride);
  end

  assign strm.ctrl_streamer = ctrl;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_datamover_ctrl_fsm.sv
// Bench for datamover_ctrl_fsm: scripted streamer responses, scoreboard of expected launches and done.
module tb_datamover_ctrl_fsm;
  import datamover_package::*;

  logic        clk_i = 1'b0;
  logic        clear_i, start_i;
  logic [31:0] src_base, dst_base, src_ts, dst_ts;
  logic [15:0] tile_len, n_tiles;
  logic        busy_o, done_o;
  logic [15:0] tile_idx_o;

  datamover_ctrl_fsm_if strm_if ();
  flags_streamer_t fl;
  ctrl_streamer_t  cs;
  assign strm_if.flags_streamer = fl;
  assign cs = strm_if.ctrl_streamer;

  datamover_ctrl_fsm #(.BYTES_PER_WORD(4), .LEN_W(16), .NT_W(16)) dut (
    .clk_i         (clk_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .src_base_i    (src_base),
    .dst_base_i    (dst_base),
    .src_tstride_i (src_ts),
    .dst_tstride_i (dst_ts),
    .tile_len_i    (tile_len),
    .n_tiles_i     (n_tiles),
    .strm          (strm_if),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .tile_idx_o    (tile_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    bit          is_done;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   ev_cnt = 0, ev_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Any req_start or done_o is an event, matched in order against the scoreboard.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (cs.data_in_source_ctrl.req_start || cs.data_out_sink_ctrl.req_start || done_o) begin
      ev_cnt++;
      ev_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 32'(done_o), 32'(e.is_done));
        if (e.is_done) begin
          chk("busy_at_done", 32'(busy_o), 32'd1);
        end else begin
          chk("req_pair", 32'(cs.data_out_sink_ctrl.req_start), 32'(cs.data_in_source_ctrl.req_start));
          chk("req_both_ready", 32'(fl.data_in_source_flags.ready_start & fl.data_out_sink_flags.ready_start), 32'd1);
          chk("src_base", cs.data_in_source_ctrl.addressgen_ctrl.base_addr, e.src);
          chk("dst_base", cs.data_out_sink_ctrl.addressgen_ctrl.base_addr, e.dst);
          chk("tot_len", cs.data_in_source_ctrl.addressgen_ctrl.tot_len, e.len);
          chk("d0_len", cs.data_out_sink_ctrl.addressgen_ctrl.d0_len, e.len);
          chk("d0_stride", cs.data_in_source_ctrl.addressgen_ctrl.d0_stride, 32'd4);
          chk("d1_len", cs.data_out_sink_ctrl.addressgen_ctrl.d1_len, 32'd0);
          chk("tile_idx", 32'(tile_idx_o), 32'(e.idx));
        end
      end
    end
  end

  task automatic cyc1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ev(input string tag, input int c0);
    int n;
    n = 0;
    while (ev_cnt == c0 && n < 100) begin
      cyc1();
      n++;
    end
    if (ev_cnt == c0) chk({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic set_ready(input logic s, input logic k);
    fl.data_in_source_flags.ready_start = s;
    fl.data_out_sink_flags.ready_start  = k;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_idx"}, 32'(tile_idx_o), 32'd0);
    chk({tag, "_req"}, 32'(cs.data_in_source_ctrl.req_start | cs.data_out_sink_ctrl.req_start), 32'd0);
    chk({tag, "_src_agen"}, 32'(|cs.data_in_source_ctrl.addressgen_ctrl), 32'd0);
    chk({tag, "_dst_agen"}, 32'(|cs.data_out_sink_ctrl.addressgen_ctrl), 32'd0);
  endtask

  // hold: cycles the sink stays not-ready after start; ga/gb: done pulse offsets from WAIT entry;
  // fd: cycles the FIFO stays non-empty after both dones; abort_tile: clear+start in that tile's WAIT.
  task automatic run_job(input logic [31:0] sb, input logic [31:0] db, input logic [31:0] ss,
                         input logic [31:0] ds, input logic [15:0] len, input logic [15:0] nt,
                         input int hold, input int ga, input int gb, input int fd, input int abort_tile);
    exp_t e;
    int   n0, e0, mc, m;
    bit   zero;
    src_base = sb; dst_base = db; src_ts = ss; dst_ts = ds; tile_len = len; n_tiles = nt;
    set_ready(1'b1, hold == 0);
    fl.tcdm_fifo_empty = 1'b1;
    zero = (nt == 0) || (len == 0);
    if (!zero) begin
      for (int i = 0; i < int'(nt); i++) begin
        e.is_done = 1'b0;
        e.src = sb + ss * 32'(i);
        e.dst = db + ds * 32'(i);
        e.len = 32'(len);
        e.idx = i;
        exp_q.push_back(e);
      end
    end
    e = '{is_done: 1'b1, src: 32'd0, dst: 32'd0, len: 32'd0, idx: 0};
    exp_q.push_back(e);

    e0 = ev_cnt;
    start_i = 1'b1;
    n0 = cyc;
    cyc1();
    start_i = 1'b0;

    if (zero) begin
      chk("zero_busy_hi", 32'(busy_o), 32'd1);
      chk("zero_done_hi", 32'(done_o), 32'd1);
      cyc1();
      chk("zero_busy_lo", 32'(busy_o), 32'd0);
      chk("zero_done_lo", 32'(done_o), 32'd0);
      chk("zero_lat", 32'(ev_cyc), 32'(n0 + 1));
      chk("zero_events", 32'(ev_cnt - e0), 32'd1);
      return;
    end

    if (hold > 0) begin
      repeat (hold) cyc1();
      chk("no_req_while_sink_busy", 32'(ev_cnt), 32'(e0));
      set_ready(1'b1, 1'b1);
    end
    wait_ev("first_req", e0);
    chk("first_req_lat", 32'(ev_cyc), 32'(n0 + 1 + hold));

    for (int t = 0; t < int'(nt); t++) begin
      set_ready(1'b0, 1'b0);
      fl.tcdm_fifo_empty = (fd == 0);
      if (t == abort_tile) begin
        clear_i = 1'b1;
        start_i = 1'b1;
        set_ready(1'b1, 1'b1);
        cyc1();
        clear_i = 1'b0;
        start_i = 1'b0;
        exp_q.delete();
        chk_reset_outputs("after_clear");
        e0 = ev_cnt;
        repeat (5) cyc1();
        chk("idle_after_clear", 32'(ev_cnt), 32'(e0));
        return;
      end
      m  = (ga > gb) ? ga : gb;
      mc = 0;
      for (int k = 0; k <= m; k++) begin
        fl.data_in_source_flags.done = (k == ga);
        fl.data_out_sink_flags.done  = (k == gb);
        if (k == m) mc = cyc;
        cyc1();
      end
      fl.data_in_source_flags.done = 1'b0;
      fl.data_out_sink_flags.done  = 1'b0;
      if (fd > 0) repeat (fd) cyc1();
      fl.tcdm_fifo_empty = 1'b1;
      set_ready(1'b1, 1'b1);
      e0 = ev_cnt;
      wait_ev("tile_end", e0);
      chk("tile_end_lat", 32'(ev_cyc), 32'(mc + 3 + fd));
    end
    chk("job_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_after_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    clear_i = 1'b1;
    start_i = 1'b0;
    src_base = '0; dst_base = '0; src_ts = '0; dst_ts = '0; tile_len = '0; n_tiles = '0;
    fl = '0;
    repeat (3) cyc1();
    chk_reset_outputs("reset");
    set_ready(1'b1, 1'b1);
    cyc1();
    chk("reset_req_ready_hi", 32'(cs.data_in_source_ctrl.req_start), 32'd0);
    clear_i = 1'b0;
    cyc1();

    run_job(32'h1000, 32'h2000, 32'h40, 32'h80, 16'd16, 16'd3, 0, 0, 0, 0, -1);
    run_job(32'h4000, 32'h5000, 32'h20, 32'h20, 16'd8, 16'd2, 5, 0, 7, 0, -1);
    run_job(32'h6000, 32'h7000, 32'h10, 32'h10, 16'd4, 16'd2, 0, 2, 1, 10, -1);
    run_job(32'h8000, 32'h9000, 32'h4, 32'h4, 16'd16, 16'd0, 0, 0, 0, 0, -1);
    run_job(32'h8000, 32'h9000, 32'h4, 32'h4, 16'd0, 16'd2, 0, 0, 0, 0, -1);
    run_job(32'hA000, 32'hB000, 32'h40, 32'h40, 16'd16, 16'd3, 0, 0, 0, 0, 1);
    run_job(32'h1000, 32'h2000, 32'h40, 32'h80, 16'd16, 16'd3, 0, 3, 0, 2, -1);
    run_job(32'hFFFF_FF80, 32'h3000, 32'h40, 32'h100, 16'd32, 16'd3, 0, 1, 0, 0, -1);

    repeat (3) cyc1();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected completion within 50000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
